// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port integer register file.
package regfile_pkg;

    // Default data width (RV32)
    localparam int XLEN_DEF  = 32;
    // Default number of architectural registers
    localparam int NREGS_DEF = 32;
    // Default number of read ports
    localparam int NRD_DEF   = 2;
    // Index of the hardwired-zero register (x0)
    localparam int REG_ZERO  = 0;

endpackage : regfile_pkg

// File: rtl/regfile_mp_if.sv
// Bus between decode/writeback and the register file: read ports,
// write port, issue port and the scoreboard view.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rs_busy;
    logic                reg_write;
    logic [AW-1:0]       rd;
    logic [XLEN-1:0]     datain;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic [NREGS-1:0]    busy_vec;

    // Pipeline side: presents addresses, writes and issues
    modport master (
        output rs_addr, reg_write, rd, datain, iss_valid, iss_rd,
        input  rd_data, rs_busy, busy_vec
    );

    // Register file side
    modport slave (
        input  rs_addr, reg_write, rd, datain, iss_valid, iss_rd,
        output rd_data, rs_busy, busy_vec
    );

endinterface : regfile_mp_if

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue,
// cleared on writeback, with issue taking priority when both hit the
// same register in one cycle. Also provides the per-read-port busy lookup.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  NREGS    = NREGS_DEF,
    parameter int  NRD      = NRD_DEF,
    parameter int  BYPASS   = 1,
    parameter int  ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic              reg_write,
    input  logic [AW-1:0]     rd,
    input  logic [NRD*AW-1:0] rs_addr,
    output logic [NRD-1:0]    rs_busy,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_next_s;

    // Next busy vector: x0 never busy, issue (newer owner) beats writeback clear
    always_comb begin
        busy_next_s = busy_r;
        for (int r = 0; r < NREGS; r++) begin
            if ((ZERO_REG != 0) && (r == REG_ZERO)) begin
                busy_next_s[r] = 1'b0;
            end else if (iss_valid && (iss_rd == AW'(r))) begin
                busy_next_s[r] = 1'b1;
            end else if (reg_write && (rd == AW'(r))) begin
                busy_next_s[r] = 1'b0;
            end else begin
                busy_next_s[r] = busy_r[r];
            end
        end
    end

    // Busy-bit state register
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= {NREGS{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Per-port hazard lookup; a register being written now is forwarded, so not busy
    always_comb begin
        rs_busy = {NRD{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            rs_busy[i] = busy_r[rs_addr[i*AW +: AW]]
                       & ~(reg_write
                           & (rd == rs_addr[i*AW +: AW])
                           & (BYPASS != 0));
        end
    end

    assign busy_vec = busy_r;

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with hardwired x0, write-to-read
// bypass, stall hold on the registered read data and a pending-write
// scoreboard for decode hazard detection.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int  XLEN     = XLEN_DEF,
    parameter int  NREGS    = NREGS_DEF,
    parameter int  NRD      = NRD_DEF,
    parameter int  BYPASS   = 1,
    parameter int  ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    regfile_mp_if.slave  bus
);

    logic [XLEN-1:0]     mem_r [NREGS];
    logic [NRD*XLEN-1:0] rd_data_r;
    logic [NRD*XLEN-1:0] rd_next_s;
    logic                wr_en_s;
    logic [NRD-1:0]      rs_busy_s;
    logic [NREGS-1:0]    busy_vec_s;

    // A write takes effect unless it targets the hardwired-zero register
    always_comb begin
        if (bus.reg_write && !((ZERO_REG != 0) && (bus.rd == AW'(REG_ZERO)))) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Storage array; writes proceed regardless of the read stall
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_r[r] <= {XLEN{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[bus.rd] <= bus.datain;
        end
    end

    // Read data selection per port: zero register, bypassed write, or stored value
    always_comb begin
        rd_next_s = rd_data_r;
        for (int i = 0; i < NRD; i++) begin
            if ((ZERO_REG != 0) && (bus.rs_addr[i*AW +: AW] == AW'(REG_ZERO))) begin
                rd_next_s[i*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if ((BYPASS != 0) && wr_en_s && (bus.rd == bus.rs_addr[i*AW +: AW])) begin
                rd_next_s[i*XLEN +: XLEN] = bus.datain;
            end else begin
                rd_next_s[i*XLEN +: XLEN] = mem_r[bus.rs_addr[i*AW +: AW]];
            end
        end
    end

    // Registered read ports; hold during a stall
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= {(NRD*XLEN){1'b0}};
        end else if (enable) begin
            rd_data_r <= rd_next_s;
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (bus.iss_valid),
        .iss_rd    (bus.iss_rd),
        .reg_write (bus.reg_write),
        .rd        (bus.rd),
        .rs_addr   (bus.rs_addr),
        .rs_busy   (rs_busy_s),
        .busy_vec  (busy_vec_s)
    );

    assign bus.rd_data  = rd_data_r;
    assign bus.rs_busy  = rs_busy_s;
    assign bus.busy_vec = busy_vec_s;

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Directed + short random bench for regfile_mp with a reference model
// feeding an expected-result queue.
module tb_regfile_mp;

    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int NRD      = 2;
    localparam int AW       = 5;
    localparam int BYPASS   = 1;
    localparam int ZERO_REG = 1;

    logic clk = 1'b0;
    logic reset;
    logic enable;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD),
        .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    typedef struct {
        string               tag;
        logic [NRD*XLEN-1:0] rd;
        logic [NREGS-1:0]    busy;
    } exp_t;

    exp_t                sb_q[$];
    logic [XLEN-1:0]     m_mem [NREGS];
    logic [NREGS-1:0]    m_busy;
    logic [NRD*XLEN-1:0] m_rd;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_rd(input int a0, input int a1);
        bus.rs_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic drive_wr(input logic we, input int r, input logic [XLEN-1:0] d);
        bus.reg_write = we;
        bus.rd        = AW'(r);
        bus.datain    = d;
    endtask

    task automatic drive_iss(input logic v, input int r);
        bus.iss_valid = v;
        bus.iss_rd    = AW'(r);
    endtask

    // Check rs_busy before the edge, advance the model, queue the expectation,
    // clock once and compare the registered outputs.
    task automatic step(input string tag);
        exp_t             e;
        exp_t             got;
        logic [AW-1:0]    a;
        logic [NRD-1:0]   eb;
        logic [XLEN-1:0]  v;
        #1;
        if (!reset) begin
            for (int i = 0; i < NRD; i++) begin
                a = bus.rs_addr[i*AW +: AW];
                eb[i] = m_busy[a] & ~(bus.reg_write && (bus.rd == a));
            end
            chk({tag, "/rs_busy"}, 64'(bus.rs_busy), 64'(eb));
        end
        if (reset) begin
            for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
            m_busy = '0;
            m_rd   = '0;
        end else begin
            if (enable) begin
                for (int i = 0; i < NRD; i++) begin
                    a = bus.rs_addr[i*AW +: AW];
                    if (a == 0)                                  v = '0;
                    else if (bus.reg_write && (bus.rd == a))     v = bus.datain;
                    else                                         v = m_mem[a];
                    m_rd[i*XLEN +: XLEN] = v;
                end
            end
            for (int r = 1; r < NREGS; r++) begin
                if (bus.iss_valid && (int'(bus.iss_rd) == r))      m_busy[r] = 1'b1;
                else if (bus.reg_write && (int'(bus.rd) == r))     m_busy[r] = 1'b0;
            end
            m_busy[0] = 1'b0;
            if (bus.reg_write && (bus.rd != 0)) m_mem[bus.rd] = bus.datain;
        end
        e.tag  = tag;
        e.rd   = m_rd;
        e.busy = m_busy;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk({got.tag, "/rd_data"}, 64'(bus.rd_data), 64'(got.rd));
        chk({got.tag, "/busy_vec"}, 64'(bus.busy_vec), 64'(got.busy));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        drive_rd(0, 0);
        drive_wr(1'b0, 0, 32'h0);
        drive_iss(1'b0, 0);
        step("reset");
        chk("reset_rd", 64'(bus.rd_data), 64'h0);
        chk("reset_busy", 64'(bus.busy_vec), 64'h0);

        reset = 1'b0;
        drive_rd(1, 31);
        step("rd_x1_x31");
        chk("rd_x1_x31_zero", 64'(bus.rd_data), 64'h0);

        drive_rd(0, 0);
        drive_wr(1'b1, 31, 32'h0000_1234);
        step("wr_x31");

        drive_wr(1'b1, 5, 32'hDEAD_BEEF);
        step("wr_x5");

        drive_wr(1'b0, 0, 32'h0);
        drive_rd(5, 31);
        step("rd_x5_x31");
        chk("x5_port0", 64'(bus.rd_data[31:0]), 64'hDEAD_BEEF);
        chk("x31_port1", 64'(bus.rd_data[63:32]), 64'h0000_1234);

        drive_wr(1'b1, 7, 32'h1234_5678);
        drive_rd(5, 7);
        step("bypass_x7");
        chk("bypass_port1", 64'(bus.rd_data[63:32]), 64'h1234_5678);

        drive_wr(1'b1, 0, 32'hFFFF_FFFF);
        drive_rd(0, 0);
        step("wr_x0");
        drive_wr(1'b0, 0, 32'h0);
        step("rd_x0");
        chk("x0_reads_zero", 64'(bus.rd_data), 64'h0);

        drive_iss(1'b1, 0);
        step("iss_x0");
        chk("x0_never_busy", 64'(bus.busy_vec[0]), 64'h0);

        drive_iss(1'b1, 3);
        drive_rd(3, 0);
        step("iss_x3");
        chk("x3_busy_set", 64'(bus.busy_vec[3]), 64'h1);

        drive_iss(1'b0, 0);
        #1;
        chk("rs_busy_x3", 64'(bus.rs_busy[0]), 64'h1);
        step("hold_x3");

        drive_iss(1'b1, 3);
        drive_wr(1'b1, 3, 32'h0000_0033);
        step("set_clr_x3");
        chk("set_wins", 64'(bus.busy_vec[3]), 64'h1);

        drive_iss(1'b0, 0);
        drive_wr(1'b1, 3, 32'h0000_0044);
        step("clr_x3");
        chk("x3_busy_clr", 64'(bus.busy_vec[3]), 64'h0);

        drive_wr(1'b0, 0, 32'h0);
        drive_rd(5, 5);
        step("same_reg_both_ports");
        chk("both_ports_x5", 64'(bus.rd_data), {32'hDEAD_BEEF, 32'hDEAD_BEEF});

        enable = 1'b0;
        drive_wr(1'b1, 9, 32'hA5A5_A5A5);
        drive_rd(9, 9);
        step("stall_wr_x9");
        chk("stall_hold", 64'(bus.rd_data[31:0]), 64'hDEAD_BEEF);

        enable = 1'b1;
        drive_wr(1'b0, 0, 32'h0);
        step("unstall_x9");
        chk("x9_after_stall", 64'(bus.rd_data), {32'hA5A5_A5A5, 32'hA5A5_A5A5});

        reset = 1'b1;
        drive_wr(1'b1, 9, 32'h0000_0001);
        drive_iss(1'b1, 9);
        step("reset_with_wr");
        reset = 1'b0;
        drive_wr(1'b0, 0, 32'h0);
        drive_iss(1'b0, 0);
        drive_rd(9, 31);
        step("rd_after_reset");
        chk("x9_x31_cleared", 64'(bus.rd_data), 64'h0);
        chk("busy_cleared", 64'(bus.busy_vec), 64'h0);

        for (int n = 0; n < 60; n++) begin
            int pick [5];
            pick[0] = 0; pick[1] = 1; pick[2] = 2; pick[3] = 3; pick[4] = 31;
            enable = ($urandom_range(0, 3) != 0);
            drive_rd(pick[$urandom_range(0, 4)], pick[$urandom_range(0, 4)]);
            drive_wr(logic'($urandom_range(0, 1)), pick[$urandom_range(0, 4)], $urandom);
            drive_iss(logic'($urandom_range(0, 1)), pick[$urandom_range(0, 4)]);
            step("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the RISC-V core; the successor to the single-write, dual-read register file.
- Adds:
  - configurable read-port count, width and depth
  - hardwired-zero x0
  - write-to-read bypass
  - stall (enable) hold
  - per-register pending-write scoreboard, used by decode for hazard detection.
- Sits between decode (reads, issue) and writeback (write).

Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two, at least 2
- AW, $clog2(NREGS), register address width (derived; do not override)
- NRD, 2, number of read ports, 1..4
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = a read returns the pre-write value
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, and is never busy

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  read enable; 0 = stall, read outputs hold their value
- rs_addr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  registered read data; port i uses bits [i*XLEN +: XLEN]
- rs_busy  out  NRD  combinational; bit i = the register addressed by port i has a pending write
- reg_write  in  1  write strobe
- rd  in  AW  write address
- datain  in  XLEN  write data
- iss_valid  in  1  an instruction issues that will write iss_rd
- iss_rd  in  AW  destination register of the issuing instruction
- busy_vec  out  NREGS  full scoreboard, for debug and verification

Behaviour:
- Reset (reset=1 at a clock edge):
  - all NREGS registers <= 0, including the highest index
  - all busy bits <= 0
  - rd_data <= 0
  - reset overrides every other input in that cycle
  - reset asserted mid-operation discards any write or issue presented in that cycle
- Write:
  - if reg_write=1, mem[rd] <= datain at the edge
  - writes are independent of enable: writes proceed during a stall
  - with ZERO_REG=1, a write with rd=0 is dropped
- Read:
  - one-cycle latency: if enable=1, rd_data[i] <= value of mem[rs_addr[i]] at the edge
  - if enable=0, rd_data holds its previous value
  - reads and writes occur in the same cycle; no priority between them (fixes the old read-blocked-by-write behaviour)
- Bypass:
  - with BYPASS=1, reg_write=1 and rs_addr[i]==rd (and rd!=0 when ZERO_REG=1), port i captures datain
  - with BYPASS=0, port i captures the old contents
- Zero register: with ZERO_REG=1, rs_addr[i]=0 always captures 0.
- Scoreboard, per register r, evaluated at each edge:
  - set when iss_valid=1 and iss_rd=r
  - clear when reg_write=1 and rd=r
  - set and clear on the same r in the same cycle: set wins (a newer instruction owns the register)
  - set of an already-busy r: stays 1; single-outstanding-write model, no counting
  - busy[0] is constantly 0 when ZERO_REG=1
- rs_busy:
  - rs_busy[i] = busy[rs_addr[i]] & ~(reg_write & rd==rs_addr[i] & BYPASS)
  - i.e. a register being written this cycle is reported not busy when bypass is on
- Width rules:
  - addresses are full-range; no out-of-range check is needed since NREGS = 2^AW
  - no sign or zero extension; data passes through unmodified
- Multiple read ports addressing the same register all return identical data.

Decomposition:
- Shared package regfile_pkg: XLEN default, NREGS default, REG_ZERO = 0 constant.
- One natural sub-module: regfile_scoreboard (the busy-bit vector with set/clear priority and the rs_busy lookup).
- The storage array and read ports stay in regfile_mp.

Test Plan:
- Reset, then read x1 and x31 through both ports -> rd_data = 0 for both ports, busy_vec = 0.
- Write x5 = 0xDEADBEEF; next cycle read port0 = x5 -> rd_data[0] = 0xDEADBEEF one cycle after the read address is presented.
- Same cycle: write x7 = 0x12345678 and read port1 = x7 -> BYPASS=1: 0x12345678; BYPASS=0: previous x7 value (0 after reset).
- Write x0 = 0xFFFFFFFF, then read x0 -> 0; iss_valid with iss_rd=0 -> busy_vec[0] stays 0.
- iss_valid with iss_rd=3 -> busy_vec[3]=1 next cycle; rs_busy=1 for a port reading x3. Then simultaneous iss_rd=3 and write rd=3 -> busy stays 1. Then write rd=3 alone -> busy cleared.
- enable=0 with x9 written to 0xA5A5A5A5 and rs_addr=9 -> rd_data holds its old value. enable=1 -> 0xA5A5A5A5 next cycle. Reset asserted with a write to x9=0x1 in the same cycle -> x9 = 0.
